// File: rtl/display_out_overlay.sv
// Registered display output stage: per-line colour overlay bands, explosion
// monochrome-red mode with frame-counted flash, fixed 2-cycle pixel latency.
`timescale 1ns/1ps
module display_out_overlay #(
  parameter int unsigned CW           = 4,
  parameter int unsigned LINE_W       = 9,
  parameter int unsigned RED_LO       = 32,
  parameter int unsigned RED_HI       = 63,
  parameter int unsigned GRN_LO       = 184,
  parameter int unsigned GRN_HI       = 239,
  parameter logic [7:0]  FLASH_FRAMES = 8'd8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3*CW-1:0] indata,
  input  logic            DT,
  input  logic            VS,
  input  logic            EXP,
  input  logic            OVL_EN,
  output logic [CW-1:0]   RD,
  output logic [CW-1:0]   GD,
  output logic [CW-1:0]   BD
);

  typedef enum logic [1:0] {
    BAND_NONE = 2'd0,
    BAND_RED  = 2'd1,
    BAND_GRN  = 2'd2
  } band_e;

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [31:0]       RED_SPAN = 32'(RED_HI - RED_LO);
  localparam logic [31:0]       GRN_SPAN = 32'(GRN_HI - GRN_LO);

  // Edge-detect history
  logic dt_d_q, vs_d_q, exp_d_q;
  logic vs_rise, dt_fall, exp_rise;

  // Frame/line state
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [7:0]        flash_cnt_q, flash_cnt_d;
  logic              mono;

  // Band classification
  logic [31:0] line_ext, red_off, grn_off;
  band_e       band_d, band1_q;

  // Stage 1
  logic [3*CW-1:0] pix1_q;
  logic            dt1_q, mono1_q, ovl1_q;

  // Stage 2
  logic [CW-1:0] r1, g1, b1, max1;
  logic [CW-1:0] rd_d, gd_d, bd_d, rd_q, gd_q, bd_q;

  assign vs_rise  = VS & ~vs_d_q;
  assign dt_fall  = ~DT & dt_d_q;
  assign exp_rise = EXP & ~exp_d_q;

  assign mono = EXP | ((flash_cnt_q != '0) & flash_cnt_q[0]);

  // Range test as an unsigned offset compare: lo <= x <= hi  <=>  (x - lo) <= (hi - lo)
  assign line_ext = 32'(line_cnt_q);
  assign red_off  = line_ext - RED_LO;
  assign grn_off  = line_ext - GRN_LO;

  always_comb begin
    band_d = BAND_NONE;
    if (red_off <= RED_SPAN) begin
      band_d = BAND_RED;
    end else if (grn_off <= GRN_SPAN) begin
      band_d = BAND_GRN;
    end
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (vs_rise) begin
      line_cnt_d = '0;
    end else if (dt_fall && (line_cnt_q != LINE_MAX)) begin
      line_cnt_d = line_cnt_q + LINE_W'(1);
    end

    flash_cnt_d = flash_cnt_q;
    if (exp_rise) begin
      flash_cnt_d = FLASH_FRAMES;
    end else if (vs_rise && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dt_d_q      <= 1'b0;
      vs_d_q      <= 1'b0;
      exp_d_q     <= 1'b0;
      line_cnt_q  <= '0;
      flash_cnt_q <= '0;
    end else begin
      dt_d_q      <= DT;
      vs_d_q      <= VS;
      exp_d_q     <= EXP;
      line_cnt_q  <= line_cnt_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pix1_q  <= '0;
      dt1_q   <= 1'b0;
      mono1_q <= 1'b0;
      ovl1_q  <= 1'b0;
      band1_q <= BAND_NONE;
    end else begin
      pix1_q  <= indata;
      dt1_q   <= DT;
      mono1_q <= mono;
      ovl1_q  <= OVL_EN;
      band1_q <= band_d;
    end
  end

  always_comb begin
    r1 = pix1_q[3*CW-1:2*CW];
    g1 = pix1_q[2*CW-1:CW];
    b1 = pix1_q[CW-1:0];

    max1 = r1;
    if (g1 > max1) max1 = g1;
    if (b1 > max1) max1 = b1;

    rd_d = '0;
    gd_d = '0;
    bd_d = '0;
    if (dt1_q) begin
      if (mono1_q || (ovl1_q && (band1_q == BAND_RED))) begin
        rd_d = max1;
      end else if (ovl1_q && (band1_q == BAND_GRN)) begin
        gd_d = max1;
      end else begin
        rd_d = r1;
        gd_d = g1;
        bd_d = b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_q <= '0;
      gd_q <= '0;
      bd_q <= '0;
    end else begin
      rd_q <= rd_d;
      gd_q <= gd_d;
      bd_q <= bd_d;
    end
  end

  assign RD = rd_q;
  assign GD = gd_q;
  assign BD = bd_q;

endmodule

// File: tb/tb_display_out_overlay.sv
// Self-checking bench for display_out_overlay: vector table, directed
// multi-cycle sequences and randomized traffic against a frame/line model.
`timescale 1ns/1ps
module tb_display_out_overlay;

  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [3*CW-1:0] indata;
  logic            DT, VS, EXP, OVL_EN;
  logic [CW-1:0]   RD_a, GD_a, BD_a;
  logic [CW-1:0]   RD_b, GD_b, BD_b;

  always #5 CLK = ~CLK;

  display_out_overlay dut_a (
    .CLK(CLK), .RST(RST), .indata(indata), .DT(DT), .VS(VS), .EXP(EXP),
    .OVL_EN(OVL_EN), .RD(RD_a), .GD(GD_a), .BD(BD_a)
  );

  // Narrow line counter: red band at 0..5, green only at the saturation value 15.
  display_out_overlay #(
    .CW(4), .LINE_W(4), .RED_LO(0), .RED_HI(5), .GRN_LO(15), .GRN_HI(15),
    .FLASH_FRAMES(8'd8)
  ) dut_b (
    .CLK(CLK), .RST(RST), .indata(indata), .DT(DT), .VS(VS), .EXP(EXP),
    .OVL_EN(OVL_EN), .RD(RD_b), .GD(GD_b), .BD(BD_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          line_a, line_b, flash;
  bit          vs_p, dt_p, exp_p;
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [11:0] out_a, out_b;

  typedef struct {
    logic [11:0] pix;
    bit          dt;
    bit          ex;
    bit          ovl;
    logic [11:0] expv;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [11:0] pix_out(logic [11:0] p, bit dt, bit mono, bit ovl,
                                          int line, int rlo, int rhi, int glo, int ghi);
    logic [3:0] r, g, b, m;
    r = p[11:8];
    g = p[7:4];
    b = p[3:0];
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    if (!dt) return 12'h000;
    if (mono || (ovl && line >= rlo && line <= rhi)) return {m, 8'h00};
    if (ovl && line >= glo && line <= ghi) return {4'h0, m, 4'h0};
    return p;
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    line_a = 0;
    line_b = 0;
    flash  = 0;
    vs_p   = 1'b0;
    dt_p   = 1'b0;
    exp_p  = 1'b0;
    qa.delete();
    qb.delete();
    qa.push_back(12'h000);
    qb.push_back(12'h000);
  endtask

  // One pixel: drive, predict, clock, update model, compare both DUTs.
  task automatic step(logic [11:0] p, bit dt, bit vs, bit ex, bit ovl);
    bit vs_r, dt_f, ex_r, mono;
    indata = p;
    DT     = dt;
    VS     = vs;
    EXP    = ex;
    OVL_EN = ovl;
    vs_r = vs && !vs_p;
    dt_f = !dt && dt_p;
    ex_r = ex && !exp_p;
    mono = ex || (flash % 2 == 1);
    qa.push_back(pix_out(p, dt, mono, ovl, line_a, 32, 63, 184, 239));
    qb.push_back(pix_out(p, dt, mono, ovl, line_b, 0, 5, 15, 15));
    @(posedge CLK);
    if (vs_r) begin
      line_a = 0;
      line_b = 0;
    end else if (dt_f) begin
      line_a = (line_a < 511) ? line_a + 1 : 511;
      line_b = (line_b < 15) ? line_b + 1 : 15;
    end
    if (ex_r) flash = 8;
    else if (vs_r && flash > 0) flash = flash - 1;
    vs_p  = vs;
    dt_p  = dt;
    exp_p = ex;
    #1;
    out_a = {RD_a, GD_a, BD_a};
    out_b = {RD_b, GD_b, BD_b};
    check("model_a", out_a, qa.pop_front());
    check("model_b", out_b, qb.pop_front());
  endtask

  task automatic hold(logic [11:0] p, bit dt, bit vs, bit ex, bit ovl);
    for (int i = 0; i < 3; i++) step(p, dt, vs, ex, ovl);
  endtask

  task automatic lines(int n, logic [11:0] p, bit ovl);
    for (int i = 0; i < n; i++) begin
      step(p, 1'b1, 1'b0, 1'b0, ovl);
      step(p, 1'b0, 1'b0, 1'b0, ovl);
    end
  endtask

  task automatic vs_pulse(logic [11:0] p);
    step(p, 1'b1, 1'b1, 1'b0, 1'b0);
    step(p, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(bit vs_hold);
    #2;
    RST = 1'b1;
    VS  = vs_hold;
    #1;
    check("async_reset_a", {RD_a, GD_a, BD_a}, 12'h000);
    check("async_reset_b", {RD_b, GD_b, BD_b}, 12'h000);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit rdt, rex;
    RST = 1'b1; indata = '0; DT = 1'b0; VS = 1'b0; EXP = 1'b0; OVL_EN = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_a", {RD_a, GD_a, BD_a}, 12'h000);
    @(negedge CLK);
    RST = 1'b0;
    step(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("first_after_reset", out_a, 12'h000);

    vecs[0] = '{12'hA53, 1'b1, 1'b0, 1'b0, 12'hA53};
    vecs[1] = '{12'hA53, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{12'h294, 1'b1, 1'b1, 1'b0, 12'h900};
    vecs[3] = '{12'h294, 1'b0, 1'b1, 1'b0, 12'h000};
    vecs[4] = '{12'h294, 1'b1, 1'b0, 1'b1, 12'h294};
    vecs[5] = '{12'h7C1, 1'b1, 1'b1, 1'b1, 12'hC00};
    vecs[6] = '{12'h3E8, 1'b1, 1'b0, 1'b0, 12'h3E8};
    for (int i = 0; i < 7; i++) begin
      hold(vecs[i].pix, vecs[i].dt, 1'b0, vecs[i].ex, vecs[i].ovl);
      check($sformatf("vec%0d", i), out_a, vecs[i].expv);
    end

    // Exact 2-cycle latency and asynchronous reset
    do_reset(1'b0);
    step(12'hA53, 1'b1, 1'b0, 1'b0, 1'b0);
    step(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("latency_1", out_a, 12'hA53);
    step(12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("latency_2", out_a, 12'h000);
    hold(12'hA53, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0);

    // Overlay bands
    vs_pulse(12'hFFF);
    lines(40, 12'hFFF, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("red_band", out_a, 12'hF00);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovl_off_line40", out_a, 12'hFFF);
    lines(60, 12'hFFF, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("no_band_line100", out_a, 12'hFFF);
    lines(100, 12'hFFF, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("green_band", out_a, 12'h0F0);
    step(12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("dtfall_vsrise_clear", out_a, 12'hFFF);

    // Line counter saturation on the narrow variant
    do_reset(1'b0);
    lines(14, 12'hFFF, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("narrow_line14", out_b, 12'hFFF);
    lines(6, 12'hFFF, 1'b1);
    hold(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("narrow_saturate", out_b, 12'h0F0);

    // Flash burst: blink on odd remaining counts
    do_reset(1'b0);
    step(12'h294, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("flash_cnt%0d", 8 - k), out_a, ((8 - k) % 2 == 1) ? 12'h900 : 12'h294);
      if (k < 8) vs_pulse(12'h294);
    end

    // EXP rise with VS rise: load wins; retrigger mid-burst reloads
    do_reset(1'b0);
    step(12'h294, 1'b1, 1'b1, 1'b1, 1'b0);
    hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
    check("exp_vs_load", out_a, 12'h294);
    vs_pulse(12'h294);
    hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
    check("exp_vs_next", out_a, 12'h900);
    for (int k = 0; k < 4; k++) vs_pulse(12'h294);
    hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
    check("flash_at3", out_a, 12'h900);
    step(12'h294, 1'b1, 1'b0, 1'b1, 1'b0);
    hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
    check("retrigger_8", out_a, 12'h294);
    vs_pulse(12'h294);
    hold(12'h294, 1'b1, 1'b0, 1'b0, 1'b0);
    check("retrigger_7", out_a, 12'h900);

    // Randomized traffic, with one reset released while VS is high
    rdt = 1'b0;
    rex = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) rdt = !rdt;
      if ($urandom_range(0, 199) == 0) rex = !rex;
      if (i == 1500) begin
        do_reset(1'b1);
        step(12'($urandom), rdt, 1'b1, rex, 1'b1);
      end
      step(12'($urandom), rdt,
           (i < 1500) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 1199) == 0),
           rex, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_out_overlay.md
Name: display_out_overlay

Overview:
- Registered, parametrised successor to the arcade display output stage.
- Takes per-channel RGB pixel data of CW bits, gated by display timing DT.
- Applies a line-banded colour overlay (cellophane-style red top band, green bottom band).
- Applies an explosion monochrome-red mode with a frame-counted blinking flash.
- Sits between the video RAM shifter and the DAC/HDMI encoder; 2-cycle fixed latency.

Parameters:
- CW, 4: bits per colour channel.
- LINE_W, 9: line counter width.
- RED_LO, 32: first line of red band (inclusive).
- RED_HI, 63: last line of red band (inclusive).
- GRN_LO, 184: first line of green band (inclusive).
- GRN_HI, 239: last line of green band (inclusive).
- FLASH_FRAMES, 8: frames in a flash burst; 0 disables flash. Width 8 bits.

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  asynchronous active-high reset.
- indata  in  3*CW  pixel {R,G,B}, R in the MSBs.
- DT  in  1  display timing; active video when 1.
- VS  in  1  vertical sync, active high; rising edge marks frame start.
- EXP  in  1  explosion request (level).
- OVL_EN  in  1  overlay enable (level, sampled per pixel).
- RD  out  CW  red output.
- GD  out  CW  green output.
- BD  out  CW  blue output.

Behaviour:
- Reset (async, RST=1):
  - RD/GD/BD=0; line_cnt=0; flash_cnt=0.
  - Pipeline registers and edge-detect registers (DT_d, VS_d, EXP_d)=0.
  - Outputs are 0 on the first CLK edge after RST deasserts.
- Edges are detected against the registered previous value:
  - vs_rise = VS&~VS_d
  - dt_fall = ~DT&DT_d
  - exp_rise = EXP&~EXP_d
- line_cnt:
  - Cleared on vs_rise.
  - Otherwise incremented on dt_fall, saturating at 2^LINE_W-1.
  - vs_rise and dt_fall in the same cycle: clear wins.
- flash_cnt (8 bits):
  - Loaded with FLASH_FRAMES on exp_rise; a retrigger mid-burst reloads it.
  - Otherwise decremented on vs_rise while nonzero.
  - exp_rise and vs_rise in the same cycle: load wins, no decrement.
- mono = EXP | (flash_cnt!=0 & flash_cnt[0]).
  - EXP high gives continuous monochrome.
  - A burst blinks on odd counts only.
- Stage 1 (cycle N+1) registers:
  - indata and DT.
  - mono.
  - band code from the line_cnt value at cycle N, before any update that cycle:
    - RED if RED_LO<=line_cnt<=RED_HI, else GREEN if GRN_LO<=line_cnt<=GRN_HI, else NONE.
    - Red wins on overlap.
  - OVL_EN.
- Stage 2 (cycle N+2) computes outputs from the stage-1 values, in priority order:
  - DT1=0: RD=GD=BD=0.
  - mono1=1: RD=max(R1,G1,B1); GD=BD=0.
  - OVL1=1 and band RED: RD=max(R,G,B); GD=BD=0.
  - OVL1=1 and band GREEN: GD=max(R,G,B); RD=BD=0.
  - Otherwise pass-through: RD=R1, GD=G1, BD=B1.
- Latency:
  - Exactly 2 CLK cycles from indata/DT to RD/GD/BD; no bubbles, no backpressure.
  - Control inputs (EXP, OVL_EN, VS) affect the pixel sampled in the same cycle as those inputs, and the next pixels.
- Reset mid-frame:
  - Outputs clear immediately; counters zero.
  - After release, the first vs_rise requires VS to go 0→1 relative to the reset value 0. VS held high through reset release counts as a rise.
- FLASH_FRAMES=0: exp_rise loads 0, so no flash; level EXP still forces mono.

Test Plan:
- Reset and pass-through:
  - RST pulse mid-stream → RD/GD/BD=0 asynchronously.
  - Then indata={4'hA,4'h5,4'h3}, DT=1, OVL_EN=0, EXP=0 → RD=A, GD=5, BD=3 exactly 2 cycles later.
  - DT=0 with the same data → outputs 0.
- Monochrome level:
  - EXP=1, indata={4'h2,4'h9,4'h4}, DT=1 → RD=9, GD=BD=0 after 2 cycles.
  - EXP=1, DT=0 → all 0.
- Overlay bands:
  - After vs_rise, give 40 DT high/low lines; OVL_EN=1, pixel {F,F,F} → RD=F, GD=BD=0.
  - Continue to line 200 → GD=F, RD=BD=0.
  - Line 100 → {F,F,F} pass-through.
  - OVL_EN=0 at line 40 → pass-through.
- Flash burst:
  - EXP pulse 1 cycle, FLASH_FRAMES=8, then 8 VS pulses.
  - flash_cnt runs 8,7,…,0.
  - Mono applies in frames with counts 7,5,3,1; normal output in frames with counts 8,6,4,2.
  - No mono after the 8th VS.
- Simultaneous events:
  - EXP rise on the same cycle as a VS rise → flash_cnt=FLASH_FRAMES, not decremented.
  - DT fall coincident with VS rise → line_cnt=0.
  - Retrigger at flash_cnt=3 → reload to 8.
- Saturation:
  - LINE_W=4 variant, 20 lines without VS → line_cnt holds at 15, no wrap to the RED band at line 0.
